// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/response and full-adder signals of the
// bit-serial add/subtract sequencer.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
) ();
   // requester side
   logic             start;
   logic             sub;
   logic             cin_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             abort;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif
   // shared 1-bit full-adder cell
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_s;
   logic             fa_cout;

   // Sequencer side.
   modport slave (
      input  start, sub, cin_in, a_in, b_in, abort, fa_s, fa_cout,
      output ready, busy, done, sum, cout, fa_a, fa_b, fa_cin
`ifdef SERIAL_ADD_OVF_EN
      , output ovf
`endif
   );

   // Requester plus full-adder side.
   modport master (
      output start, sub, cin_in, a_in, b_in, abort, fa_s, fa_cout,
      input  ready, busy, done, sum, cout, fa_a, fa_b, fa_cin
`ifdef SERIAL_ADD_OVF_EN
      , input ovf
`endif
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer driving one external
// 1-bit full-adder cell. Operands are shifted LSB-first through the cell,
// the cell's carry is fed back through carry_reg, and the result is
// assembled in a shift register. DONE pulses WIDTH cycles after accept.
// Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow flag (ovf).
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_add_ctrl_if.slave bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int RES_W = WIDTH - 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DONE_ST = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   // Only WIDTH-1 result bits are stored: the final bit comes straight
   // from the cell on the last edge and goes directly into sum_reg.
   logic [RES_W-1:0] res_sh_reg;
   logic             carry_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_reg;
`endif

   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] b_load;
   logic [RES_W-1:0] res_shift;
   logic [WIDTH-1:0] sum_final;

   logic accept;
   logic step;
   logic last_bit;
   logic ready_int;
   logic busy_int;
   logic done_int;

   // Per-bit shift, operand-load and result-assembly networks.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_op_bit
         // Subtraction is A + ~B + 1, so B is inverted on load.
         assign b_load[gi] = bus.b_in[gi] ^ bus.sub;
         if (gi == WIDTH - 1) begin : g_top
            assign a_shift[gi] = 1'b0;
            assign b_shift[gi] = 1'b0;
         end else begin : g_mid
            assign a_shift[gi] = a_sh_reg[gi+1];
            assign b_shift[gi] = b_sh_reg[gi+1];
         end
      end

      for (gi = 0; gi < RES_W; gi++) begin : g_res_bit
         if (gi == RES_W - 1) begin : g_top
            assign res_shift[gi] = bus.fa_s;
         end else begin : g_mid
            assign res_shift[gi] = res_sh_reg[gi+1];
         end
      end

      for (gi = 0; gi < WIDTH; gi++) begin : g_sum_bit
         if (gi == WIDTH - 1) begin : g_top
            assign sum_final[gi] = bus.fa_s;
         end else begin : g_mid
            assign sum_final[gi] = res_sh_reg[gi];
         end
      end
   endgenerate

   assign last_bit = (cnt_reg == LAST_BIT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake decode; ABORT only matters while running,
   // and START wins over ABORT in DONE_ST.
   always_comb begin
      state_next = state_reg;
      ready_int  = 1'b0;
      busy_int   = 1'b0;
      done_int   = 1'b0;
      accept     = 1'b0;
      step       = 1'b0;
      case (state_reg)
         IDLE: begin
            ready_int = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy_int = 1'b1;
            if (bus.abort) begin
               state_next = IDLE;
            end else begin
               step = 1'b1;
               if (last_bit) begin
                  state_next = DONE_ST;
               end
            end
         end
         DONE_ST: begin
            ready_int = 1'b1;
            done_int  = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand capture, serial stepping and result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         res_sh_reg <= '0;
         carry_reg  <= 1'b0;
         cnt_reg    <= '0;
         sum_reg    <= '0;
         cout_reg   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_reg    <= 1'b0;
`endif
      end else if (accept) begin
         a_sh_reg   <= bus.a_in;
         b_sh_reg   <= b_load;
         res_sh_reg <= '0;
         carry_reg  <= bus.sub ? 1'b1 : bus.cin_in;
         cnt_reg    <= '0;
      end else if (step) begin
         a_sh_reg   <= a_shift;
         b_sh_reg   <= b_shift;
         res_sh_reg <= res_shift;
         carry_reg  <= bus.fa_cout;
         cnt_reg    <= cnt_reg + 1'b1;
         if (last_bit) begin
            sum_reg  <= sum_final;
            cout_reg <= bus.fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // Carry into the sign bit differs from carry out of it.
            ovf_reg  <= carry_reg ^ bus.fa_cout;
`endif
         end
      end
   end

   assign bus.ready  = ready_int;
   assign bus.busy   = busy_int;
   assign bus.done   = done_int;
   assign bus.sum    = sum_reg;
   assign bus.cout   = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf    = ovf_reg;
`endif
   // The adder cell only sees live operands while running.
   assign bus.fa_a   = busy_int & a_sh_reg[0];
   assign bus.fa_b   = busy_int & b_sh_reg[0];
   assign bus.fa_cin = busy_int & carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed scoreboard bench for serial_add_ctrl with a
// behavioural full-adder cell. Define SERIAL_ADD_OVF_EN to check ovf too.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb_q[$];

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural full-adder cell.
   assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
   assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every DONE pulse.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn cycle=%0d sum=%02h cout=%0b (expected sum=%02h cout=%0b at cycle %0d)",
                     cyc, bus.sum, bus.cout, e.sum, e.cout, e.cyc);
            check("sum", 32'(bus.sum), 32'(e.sum));
            check("cout", 32'(bus.cout), 32'(e.cout));
            check("done_latency", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(bus.ready), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_sum"}, 32'(bus.sum), 32'd0);
      check({tag, "_cout"}, 32'(bus.cout), 32'd0);
      check({tag, "_fa"}, 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
   endtask

   // Issue one operation; returns the cycle number of the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci, input bit push,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        output int acc);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!bus.ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_start", 32'(bus.ready), 32'd1);
      bus.a_in   = a;
      bus.b_in   = b;
      bus.sub    = s;
      bus.cin_in = ci;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) sb_q.push_back('{es, ec, eo, acc + W});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      int acc;
      issue(a, b, s, ci, 1'b1, es, ec, eo, acc);
      repeat (W + 2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      bus.start  = 1'b0;
      bus.sub    = 1'b0;
      bus.cin_in = 1'b0;
      bus.a_in   = '0;
      bus.b_in   = '0;
      bus.abort  = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 0x3C + 0x0F + 1; also look at handshake and cell drive mid-run.
      issue(8'h3C, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h4C, 1'b0, 1'b0, acc);
      check("run_busy", 32'(bus.busy), 32'd1);
      check("run_ready", 32'(bus.ready), 32'd0);
      check("run_fa_bits", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'b011);
      repeat (W + 2) @(negedge clk);
      check("idle_fa_bits", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);

      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op(8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0);
      run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

      // Back-to-back: START pulse during RUN is ignored, START held into
      // DONE_ST is accepted with no idle cycle.
      issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, acc);
      bus.a_in  = 8'hAA;
      bus.b_in  = 8'hAA;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < acc + W - 1) @(negedge clk);
      bus.a_in  = 8'h20;
      bus.b_in  = 8'h05;
      bus.sub   = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      sb_q.push_back('{8'h1B, 1'b1, 1'b0, cyc + W});
      check("b2b_accept_cycle", 32'(cyc), 32'(acc + W + 1));
      @(negedge clk);
      bus.start = 1'b0;
      repeat (W + 2) @(negedge clk);

      // ABORT in the 4th RUN cycle after restoring SUM=0x4C.
      run_op(8'h3C, 8'h0F, 1'b0, 1'b1, 8'h4C, 1'b0, 1'b0);
      issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
      repeat (3) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_ready", 32'(bus.ready), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_sum_held", 32'(bus.sum), 32'h4C);
      check("abort_cout_held", 32'(bus.cout), 32'd0);
      repeat (W + 2) @(negedge clk);

      // Asynchronous reset mid-run, then a fresh op.
      issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer. One external 1-bit full-adder cell (A,B,Cin -> S,Cout) computes a WIDTH-bit sum over WIDTH cycles.
- Captures operands on a START/READY handshake and shifts them LSB-first into the cell.
- Feeds the cell's carry back through a register and assembles the result. Pulses DONE when finished.
- Sits between a requesting control unit and the shared full-adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  operation request; accepted when START=1 and READY=1.
- SUB  input  1  sampled with START; 1 computes A_IN-B_IN, 0 computes A_IN+B_IN+CIN_IN.
- CIN_IN  input  1  carry-in for add; ignored when SUB=1.
- A_IN  input  WIDTH  operand A.
- B_IN  input  WIDTH  operand B.
- ABORT  input  1  cancels an operation in progress.
- READY  output  1  controller can accept START.
- BUSY  output  1  serial operation in progress.
- DONE  output  1  one-cycle pulse; SUM/COUT valid.
- SUM  output  WIDTH  result, held until the next accepted START.
- COUT  output  1  final carry-out; for SUB, 1 means no borrow.
- FA_A  output  1  to full-adder A.
- FA_B  output  1  to full-adder B.
- FA_CIN  output  1  to full-adder Cin.
- FA_S  input  1  from full-adder S.
- FA_COUT  input  1  from full-adder Cout.

Behaviour:
- States: IDLE, RUN, DONE_ST. Registered state; outputs decoded from state and regs.
- Reset (async, RST_N=0): state=IDLE, READY=1, BUSY=0, DONE=0, SUM=0, COUT=0, FA_A/FA_B/FA_CIN=0, shift regs, carry reg and bit counter=0.
- READY=1 in IDLE and DONE_ST. BUSY=1 only in RUN. DONE=1 only in DONE_ST.
- Accept (START&READY at edge): a_sh<=A_IN, b_sh<=SUB?~B_IN:B_IN, carry<=SUB?1:CIN_IN, cnt<=0, res_sh<=0, state<=RUN.
- RUN, each cycle (combinational drive): FA_A=a_sh[0], FA_B=b_sh[0], FA_CIN=carry.
- RUN, each edge: a_sh and b_sh shift right, res_sh<={FA_S,res_sh[WIDTH-1:1]}, carry<=FA_COUT, cnt++.
- End of RUN: on the edge where cnt==WIDTH-1, state<=DONE_ST, SUM<=final shifted result, COUT<=FA_COUT.
- FA_* outputs are 0 outside RUN.
- Latency: DONE high exactly WIDTH cycles after the accepting edge. Throughput: one op per WIDTH+1 cycles.
- DONE_ST lasts one cycle, then returns to IDLE. If START=1 in DONE_ST, the new op is accepted and state goes directly to RUN (back-to-back, no idle cycle).
- START while BUSY: ignored, no queuing.
- ABORT=1 in RUN: next edge state<=IDLE, no DONE, SUM/COUT keep their previous values. ABORT ignored in IDLE/DONE_ST. ABORT and START together in DONE_ST: START wins.
- Arithmetic is modulo 2^WIDTH. No overflow indication unless the optional feature is compiled in.
- Reset mid-RUN: immediate return to reset values; partial result discarded.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output OVF (1 bit, reset 0). During the last RUN bit (cnt==WIDTH-1), OVF<=carry^FA_COUT, i.e. signed two's-complement overflow. OVF is updated with SUM and held with it; ABORT leaves it unchanged.
- Not defined: no OVF port and no associated logic.

Test Plan:
- WIDTH=8, bench full-adder model. START with A_IN=0x3C, B_IN=0x0F, CIN_IN=1, SUB=0 -> DONE 8 cycles after accept, SUM=0x4C, COUT=0.
- A_IN=0xFF, B_IN=0x01, SUB=0 -> SUM=0x00, COUT=1. Then SUB=1, A_IN=0x10, B_IN=0x01 -> SUM=0x0F, COUT=1. Then SUB=1, A_IN=0x01, B_IN=0x02 -> SUM=0xFF, COUT=0.
- Back-to-back: hold START=1 through DONE_ST with a new operand pair -> second DONE exactly 9 cycles after the first. START pulses during RUN have no effect.
- ABORT at the 4th RUN cycle -> IDLE next edge, no DONE, SUM keeps the previous 0x4C, READY=1.
- RST_N low mid-RUN -> all outputs at reset values immediately. A new op after release completes correctly: 0x55+0xAA -> 0xFF, COUT=0.
- SERIAL_ADD_OVF_EN defined: 0x7F+0x01 -> SUM=0x80, OVF=1. 0x80-0x01 -> SUM=0x7F, OVF=1. 0x10+0x20 -> OVF=0.
